// File: rtl/signal_lamp_driver.sv
// Lamp driver for the intersection light sequencer: decodes the phase code into
// one-hot lamp drives and latches into a flashing-red fail-safe on any code fault.
module signal_lamp_driver #(
  parameter int unsigned MIN_DWELL  = 1,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       light_in,
  input  logic             fault_clr,
  output logic             lamp_red,
  output logic             lamp_yellow,
  output logic             lamp_green,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic [CNT_W-1:0] phase_count
);

  localparam int unsigned      FL_W      = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] DWELL_MIN = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  localparam logic [1:0] PH_GREEN  = 2'b00;
  localparam logic [1:0] PH_YELLOW = 2'b01;
  localparam logic [1:0] PH_RED    = 2'b10;
  localparam logic [1:0] PH_BAD    = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_FAULT
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE  = 2'b00,
    FC_CODE  = 2'b01,
    FC_TRANS = 2'b10,
    FC_DWELL = 2'b11
  } fcode_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamps_t;

  localparam lamps_t LAMPS_RED = '{red: 1'b1, yellow: 1'b0, green: 1'b0};

  function automatic lamps_t decode(input logic [1:0] code);
    lamps_t l;
    l = '0;
    case (code)
      PH_GREEN:  l.green  = 1'b1;
      PH_YELLOW: l.yellow = 1'b1;
      PH_RED:    l.red    = 1'b1;
      default:   l        = '0;
    endcase
    return l;
  endfunction

  // Only the forward cycle green -> yellow -> red -> green is a legal change.
  function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
    return ((from == PH_GREEN)  && (to == PH_YELLOW)) ||
           ((from == PH_YELLOW) && (to == PH_RED))    ||
           ((from == PH_RED)    && (to == PH_GREEN));
  endfunction

  state_e           state_q,      state_d;
  lamps_t           lamps_q,      lamps_d;
  logic             fault_q,      fault_d;
  fcode_e           fault_code_q, fault_code_d;
  logic [CNT_W-1:0] dwell_q,      dwell_d;
  logic [CNT_W-1:0] phase_q,      phase_d;
  logic [1:0]       last_q,       last_d;
  logic [FL_W-1:0]  flash_q,      flash_d;

  logic             fault_hit;
  fcode_e           fault_kind;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    lamps_d      = lamps_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    dwell_d      = dwell_q;
    phase_d      = phase_q;
    last_d       = last_q;
    flash_d      = flash_q;
    fault_hit    = 1'b0;
    fault_kind   = FC_NONE;

    case (state_q)
      ST_INIT: begin
        if (light_in == PH_BAD) begin
          fault_hit  = 1'b1;
          fault_kind = FC_CODE;
        end else begin
          state_d = ST_RUN;
          last_d  = light_in;
          lamps_d = decode(light_in);
          dwell_d = CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (light_in == PH_BAD) begin
          fault_hit  = 1'b1;
          fault_kind = FC_CODE;
        end else if (light_in != last_q) begin
          if (!legal_step(last_q, light_in)) begin
            fault_hit  = 1'b1;
            fault_kind = FC_TRANS;
          end else if (dwell_q < DWELL_MIN) begin
            fault_hit  = 1'b1;
            fault_kind = FC_DWELL;
          end else begin
            lamps_d = decode(light_in);
            last_d  = light_in;
            dwell_d = CNT_W'(1);
            phase_d = phase_q + CNT_W'(1);
          end
        end else if (dwell_q != DWELL_MAX) begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end

      ST_FAULT: begin
        if (fault_clr) begin
          state_d      = ST_INIT;
          lamps_d      = LAMPS_RED;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
          dwell_d      = '0;
          flash_d      = '0;
        end else if (flash_q == FL_LAST) begin
          lamps_d.red = ~lamps_q.red;
          flash_d     = '0;
        end else begin
          flash_d = flash_q + FL_W'(1);
        end
      end

      default: state_d = ST_INIT;
    endcase

    // Fault entry overrides whatever the state logic proposed; dwell stays frozen.
    if (fault_hit) begin
      state_d      = ST_FAULT;
      fault_d      = 1'b1;
      fault_code_d = fault_kind;
      lamps_d      = LAMPS_RED;
      flash_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q      <= ST_INIT;
      lamps_q      <= LAMPS_RED;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      dwell_q      <= '0;
      phase_q      <= '0;
      last_q       <= PH_RED;
      flash_q      <= '0;
    end else begin
      state_q      <= state_d;
      lamps_q      <= lamps_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      dwell_q      <= dwell_d;
      phase_q      <= phase_d;
      last_q       <= last_d;
      flash_q      <= flash_d;
    end
  end

  assign lamp_red    = lamps_q.red;
  assign lamp_yellow = lamps_q.yellow;
  assign lamp_green  = lamps_q.green;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign dwell_cnt   = dwell_q;
  assign phase_count = phase_q;

endmodule
